// File: rtl/tape_buf_reader.sv
// tape_buf_reader: byte-read server for the tape player, opening buff_rd_en windows
// and backing them with a one-word SDRAM line cache.
module tape_buf_reader #(
  parameter int MIN_WIN = 4,
  parameter int GAP = 12
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        invalidate,
  output logic        buff_rd_en,
  input  logic        buff_rd,
  input  logic [24:0] buff_addr,
  output logic [7:0]  buff_din,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        busy
);
  typedef enum logic [2:0] {S_GAP, S_OPEN, S_HOLD, S_FETCH, S_CLOSE} state_t;
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  // window states close once this many cycles have elapsed since OPEN (CLOSE adds the last one)
  localparam logic [15:0] WIN_LAST = 16'(MIN_WIN - 2);
  state_t state;
  logic [15:0] cnt, line;
  logic [23:0] tag;
  logic valid, inv_seen, sel, hit;
  logic [15:0] cnt_inc;
  assign hit = valid && !invalidate && tag == buff_addr[24:1];
  assign cnt_inc = cnt + 16'(cnt != '1);
  assign busy = mem_req;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= S_GAP;
      cnt <= '0;
      buff_rd_en <= 1'b0;
      buff_din <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      line <= '0;
      tag <= '0;
      valid <= 1'b0;
      inv_seen <= 1'b0;
      sel <= 1'b0;
    end else begin
      if (invalidate) valid <= 1'b0;
      if (invalidate && state != S_GAP) inv_seen <= 1'b1;
      case (state)
        S_GAP: begin
          cnt <= (invalidate || cnt == GAP_LAST) ? '0 : cnt + 16'd1;
          if (!invalidate && cnt == GAP_LAST) begin
            state <= S_OPEN;
            buff_rd_en <= 1'b1;
          end
        end
        S_OPEN: begin
          cnt <= 16'd1;
          sel <= buff_addr[0];
          if (buff_rd && hit) buff_din <= buff_addr[0] ? line[15:8] : line[7:0];
          if (buff_rd && !hit) begin
            mem_req <= 1'b1;
            mem_addr <= buff_addr[24:1];
          end
          state <= (buff_rd && !hit) ? S_FETCH : S_HOLD;
        end
        S_HOLD: begin
          cnt <= cnt_inc;
          if (cnt >= WIN_LAST) state <= S_CLOSE;
        end
        S_FETCH: begin
          cnt <= cnt_inc;
          if (mem_ack) begin
            mem_req <= 1'b0;
            line <= mem_data;
            tag <= mem_addr;
            valid <= !(inv_seen || invalidate);
            buff_din <= sel ? mem_data[15:8] : mem_data[7:0];
            state <= cnt >= WIN_LAST ? S_CLOSE : S_HOLD;
          end
        end
        S_CLOSE: begin
          buff_rd_en <= 1'b0;
          cnt <= '0;
          inv_seen <= 1'b0;
          state <= S_GAP;
        end
        default: state <= S_GAP;
      endcase
    end
endmodule
